// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit programmable interval timer with prescaler and level irq.
//   clk      system clock, rising edge
//   arst     synchronous active-low reset
//   cs/rd/wr active-low chip select, read and write strobes
//   addr     register index: 0 CTRL, 1 STATUS, 2/3 RELOAD, 4/5 COUNT, 6 PRESCALE, 7 reserved
//   data_in  write data; data_out/data_oe read data and its bus drive-enable
//   irq      level interrupt request, PEND & IRQ_EN
module bus_timer #(
    parameter logic [7:0]  PRESCALE_RST = 8'h00,
    parameter logic [15:0] RELOAD_RST   = 16'h0000
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       irq
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic        auto_rl, irq_en, pend, wacc_q, racc_q;
    logic [15:0] reload, count;
    logic [7:0]  prescale, pcnt, snap, rdata;
    logic        wacc, racc, wstb, rstb, ctrl_w, load, tick, expire, run;
    assign wacc   = !cs && !wr;
    assign racc   = !cs && !rd;
    // one commit per strobe: only the first cycle of an access acts; writes mask the read side effect
    assign wstb   = wacc && !wacc_q;
    assign rstb   = racc && !racc_q && !wacc;
    assign ctrl_w = wstb && addr == 3'd0;
    assign load   = ctrl_w && data_in[3];
    assign run    = state == RUN;
    assign tick   = run && pcnt == prescale;
    // LOAD overrides a coincident tick, so it also suppresses expiry
    assign expire = tick && count == 16'd0 && !load;
    always_ff @(posedge clk) begin
        if (!arst) begin
            state    <= IDLE;
            auto_rl  <= 1'b0;
            irq_en   <= 1'b0;
            pend     <= 1'b0;
            reload   <= RELOAD_RST;
            prescale <= PRESCALE_RST;
            count    <= 16'd0;
            pcnt     <= 8'd0;
            snap     <= 8'd0;
            wacc_q   <= 1'b0;
            racc_q   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            wacc_q <= wacc;
            racc_q <= racc;
            irq    <= pend && irq_en;
            if (wstb) begin
                case (addr)
                    3'd0: begin
                        auto_rl <= data_in[1];
                        irq_en  <= data_in[2];
                    end
                    3'd2: reload[7:0]  <= data_in;
                    3'd3: reload[15:8] <= data_in;
                    3'd6: prescale     <= data_in;
                    default: ;
                endcase
            end
            if (rstb && addr == 3'd4)
                snap <= count[15:8];
            // held at 0 while idle, so an EN 0->1 write always restarts the prescaler from 0
            pcnt <= (load || !run || tick) ? 8'd0 : pcnt + 8'd1;
            if (load)
                count <= reload;
            else if (tick)
                count <= (count != 16'd0) ? count - 16'd1 : (auto_rl ? reload : count);
            // a CTRL write decides EN even on an expiry tick
            if (ctrl_w)
                state <= data_in[0] ? RUN : IDLE;
            else if (expire && !auto_rl)
                state <= IDLE;
            if (expire)
                pend <= 1'b1;
            else if (wstb && addr == 3'd1 && data_in[0])
                pend <= 1'b0;
        end
    end
    always_comb begin
        rdata = 8'h00;
        case (addr)
            3'd0: rdata = {5'b0, irq_en, auto_rl, run};
            3'd1: rdata = {6'b0, run, pend};
            3'd2: rdata = reload[7:0];
            3'd3: rdata = reload[15:8];
            3'd4: rdata = count[7:0];
            3'd5: rdata = snap;
            3'd6: rdata = prescale;
            default: rdata = 8'h00;
        endcase
    end
    // the bus is never driven while reset is held, even with rd active
    assign data_oe  = racc && arst;
    assign data_out = data_oe ? rdata : 8'h00;
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: self-checking bench for bus_timer with directed and randomized scenarios.
module tb_bus_timer;
    logic       clk = 1'b0;
    logic       arst, cs, rd, wr;
    logic [2:0] addr;
    logic [7:0] data_in, data_out;
    logic       data_oe, irq;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    bus_timer dut (
        .clk(clk), .arst(arst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // idle edge first so every strobe is a fresh access; returns just after the commit edge
    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = a; data_in = d;
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0; addr = a;
        @(negedge clk);
        v = data_out;
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (irq !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        arst = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (data_oe !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: data_oe=%b irq=%b, want 0 0", i, data_oe, irq);
            end
            checks++;
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_data_out: got %h want 00", data_out);
            end
        end
        cs = 1'b1; wr = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        arst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h want 00", a, v);
            end
        end
    endtask

    task automatic test_registers;
        logic [7:0] m [8];
        logic [7:0] d, v;
        int         wa [5] = '{0, 2, 3, 6, 7};
        for (int it = 0; it < 4; it++) begin
            foreach (m[k]) m[k] = 8'h00;
            foreach (wa[k]) begin
                d = 8'($urandom);
                if (wa[k] == 0) d = d & 8'hF6;
                write_reg(3'(wa[k]), d);
                m[wa[k]] = (wa[k] == 0) ? (d & 8'h06) : (wa[k] == 7) ? 8'h00 : d;
            end
            for (int a = 0; a < 8; a++) begin
                read_reg(3'(a), v);
                checks++;
                if (v !== m[a]) begin
                    errors++;
                    $display("FAIL reg_readback iter %0d addr %0d: got %h want %h", it, a, v, m[a]);
                end
            end
        end
    endtask

    task automatic test_oneshot;
        logic [7:0] v;
        int         n;
        write_reg(3'd2, 8'h04);
        write_reg(3'd3, 8'h00);
        write_reg(3'd6, 8'h00);
        write_reg(3'd0, 8'h0D);
        wait_irq(40, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL oneshot_latency: irq after %0d clks, want 6", n);
        end
        read_reg(3'd1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL oneshot_status: got %h want 01", v); end
        read_reg(3'd0, v);
        checks++;
        if (v !== 8'h04) begin errors++; $display("FAIL oneshot_ctrl: got %h want 04", v); end
        read_reg(3'd4, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL oneshot_count_lo: got %h want 00", v); end
        read_reg(3'd5, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL oneshot_count_hi: got %h want 00", v); end
        write_reg(3'd1, 8'h01);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear: irq=%b want 0", irq); end
    endtask

    // expiry period from a load is (RELOAD+1)*(PRESCALE+1); irq follows one clk later
    task automatic test_random_oneshot;
        int r, p, n;
        for (int it = 0; it < 5; it++) begin
            r = $urandom_range(0, 6);
            p = $urandom_range(0, 4);
            write_reg(3'd1, 8'h01);
            write_reg(3'd2, 8'(r));
            write_reg(3'd3, 8'h00);
            write_reg(3'd6, 8'(p));
            write_reg(3'd0, 8'h0D);
            wait_irq(100, n);
            checks++;
            if (n !== (r + 1) * (p + 1) + 1) begin
                errors++;
                $display("FAIL rand_oneshot reload=%0d prescale=%0d: irq after %0d clks, want %0d",
                         r, p, n, (r + 1) * (p + 1) + 1);
            end
        end
        write_reg(3'd1, 8'h01);
    endtask

    task automatic test_auto_reload;
        logic [7:0] v;
        int         n, t1, t2;
        write_reg(3'd2, 8'h02);
        write_reg(3'd3, 8'h00);
        write_reg(3'd6, 8'h03);
        write_reg(3'd0, 8'h0F);
        wait_irq(60, n);
        t1 = cyc;
        checks++;
        if (n !== 13) begin errors++; $display("FAIL auto_first: irq after %0d clks, want 13", n); end
        write_reg(3'd1, 8'h01);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL auto_clear: irq=%b want 0", irq); end
        wait_irq(60, n);
        t2 = cyc;
        checks++;
        if (t2 - t1 !== 12) begin errors++; $display("FAIL auto_period: got %0d clks want 12", t2 - t1); end
        while (cyc < t2 + 9) begin @(posedge clk); #1; end
        write_reg(3'd1, 8'h01);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL auto_set_wins: irq=%b want 1", irq); end
        read_reg(3'd1, v);
        checks++;
        if (v !== 8'h03) begin errors++; $display("FAIL auto_status: got %h want 03", v); end
        write_reg(3'd0, 8'h00);
        write_reg(3'd1, 8'h01);
    endtask

    task automatic test_atomic_read;
        logic [7:0] lo, hi;
        write_reg(3'd2, 8'h00);
        write_reg(3'd3, 8'h01);
        write_reg(3'd6, 8'h00);
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = 3'd0; data_in = 8'h09;
        @(posedge clk); #1;
        wr = 1'b1; rd = 1'b0; addr = 3'd4;
        @(negedge clk);
        lo = data_out;
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1;
        read_reg(3'd5, hi);
        checks++;
        if (lo !== 8'h00) begin errors++; $display("FAIL atomic_lo: got %h want 00", lo); end
        checks++;
        if (hi !== 8'h01) begin errors++; $display("FAIL atomic_hi: got %h want 01", hi); end
        write_reg(3'd0, 8'h00);
    endtask

    task automatic test_long_strobe;
        logic [7:0] v;
        int         n;
        write_reg(3'd1, 8'h01);
        write_reg(3'd2, 8'h00);
        write_reg(3'd3, 8'h00);
        write_reg(3'd6, 8'h03);
        write_reg(3'd0, 8'h0F);
        wait_irq(30, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL long_setup: irq after %0d clks, want 5", n); end
        cs = 1'b0; wr = 1'b0; addr = 3'd1; data_in = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                checks++;
                if (irq !== 1'b0) begin errors++; $display("FAIL long_first_clear: irq=%b want 0", irq); end
            end
            if (i == 5 || i == 10) begin
                checks++;
                if (irq !== 1'b1) begin errors++; $display("FAIL long_reset_pend at %0d: irq=%b want 1", i, irq); end
            end
        end
        cs = 1'b1; wr = 1'b1;
        write_reg(3'd0, 8'h00);
        read_reg(3'd1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL long_status: got %h want 01", v); end
    endtask

    task automatic test_mid_operation;
        logic [7:0] v;
        int         n;
        write_reg(3'd1, 8'h01);
        write_reg(3'd2, 8'h33);
        write_reg(3'd3, 8'h00);
        write_reg(3'd6, 8'h00);
        write_reg(3'd0, 8'h03);
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = 3'd0; data_in = 8'h0B;
        @(posedge clk); #1;
        wr = 1'b1; rd = 1'b0; addr = 3'd4;
        @(negedge clk);
        checks++;
        if (data_out !== 8'h33) begin errors++; $display("FAIL load_on_tick: count_lo=%h want 33", data_out); end
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1;
        write_reg(3'd0, 8'h07);
        wait_irq(200, n);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_up: irq=%b want 1 after %0d clks", irq, n); end
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = 3'd0; data_in = 8'h0F;
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; arst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: irq=%b data_oe=%b want 0 0", irq, data_oe);
        end
        arst = 1'b1;
        read_reg(3'd0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL mid_reset_ctrl: got %h want 00", v); end
        read_reg(3'd1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL mid_reset_status: got %h want 00", v); end
        read_reg(3'd4, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL mid_reset_count_lo: got %h want 00", v); end
        read_reg(3'd2, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL mid_reset_reload: got %h want 00", v); end
    endtask

    initial begin
        arst = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd0; data_in = 8'h00;
        test_reset;
        test_registers;
        test_oneshot;
        test_random_oneshot;
        test_auto_reload;
        test_atomic_read;
        test_long_strobe;
        test_mid_operation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
